// File: rtl/ctrl_interrupciones.sv
// ctrl_interrupciones
//   Interrupt controller in front of the single-cycle cpu. Rising edges on the
//   request lines are latched as pending; pending & mask feeds a fixed-priority
//   (lowest index wins) selector. A three-state handshake hands one request to
//   the cpu with its jump vector and waits for ack, then for eoi. No nesting.
// Ports
//   clk, reset      clock (rising) / asynchronous active-high reset
//   irq_in          raw request lines, clk-synchronous
//   mask_we,mask_in mask register load (1 = source enabled)
//   int_ack,int_eoi cpu handshake pulses
//   int_req         request to cpu
//   int_vector      VEC_BASE + index of the request being offered
//   in_service      handler running (between ack and eoi)
//   pending_out     pending register readback
//   mask_out        mask register readback
module ctrl_interrupciones #(
  parameter int              N_IRQ    = 8,
  parameter int              VEC_W    = 10,
  parameter logic [VEC_W-1:0] VEC_BASE = 10'h3F0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_in,
  input  logic             int_ack,
  input  logic             int_eoi,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vector,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending_out,
  output logic [N_IRQ-1:0] mask_out
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SRV  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] edge_det, elig;
  logic [IDX_W-1:0] win_idx;
  logic             ack_clr;

  assign edge_det = irq_in & ~prev_q;
  assign elig     = pend_q & mask_q;
  assign ack_clr  = (state_q == S_REQ) && int_ack;
  assign mask_d   = mask_we ? mask_in : mask_q;

  // Fixed priority: scan downward so the lowest set index is the last write.
  always_comb begin
    win_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (elig[i]) win_idx = IDX_W'(i);
  end

  // Per-line pending bit. A fresh edge beats the ack clear in the same cycle
  // so a request arriving while being acknowledged is not lost.
  for (genvar g = 0; g < N_IRQ; g++) begin : g_pend
    assign pend_d[g] = edge_det[g] |
                       (pend_q[g] & ~(ack_clr && (cur_idx_q == IDX_W'(g))));
  end

  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    case (state_q)
      S_IDLE: if (elig != '0) begin
        state_d   = S_REQ;
        cur_idx_d = win_idx;
      end
      // cur_idx stays frozen here: later arrivals or mask changes do not
      // retarget or withdraw an offered request. eoi is ignored in REQ.
      S_REQ:  if (int_ack) state_d = S_SRV;
      S_SRV:  if (int_eoi) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cur_idx_q <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      prev_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      prev_q    <= irq_in;
    end
  end

  assign int_req     = (state_q == S_REQ);
  assign in_service  = (state_q == S_SRV);
  // Zero-extend the index; the add wraps mod 2^VEC_W.
  assign int_vector  = VEC_BASE + {{(VEC_W-IDX_W){1'b0}}, cur_idx_q};
  assign pending_out = pend_q;
  assign mask_out    = mask_q;

endmodule

// File: tb/tb_ctrl_interrupciones.sv
module tb_ctrl_interrupciones;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in, mask_in;
  logic       mask_we, int_ack, int_eoi;
  logic       int_req, in_service;
  logic [9:0] int_vector;
  logic [7:0] pending_out, mask_out;

  int checks = 0;
  int errors = 0;

  ctrl_interrupciones dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we),
    .mask_in(mask_in), .int_ack(int_ack), .int_eoi(int_eoi),
    .int_req(int_req), .int_vector(int_vector), .in_service(in_service),
    .pending_out(pending_out), .mask_out(mask_out)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 offering, 2 handler running.
  logic [7:0] m_pend, m_mask, m_prev, m_edge, m_elig, m_np;
  int         m_mode, m_cur;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend = 0; m_mask = 0; m_prev = 0; m_mode = 0; m_cur = 0;
    end else begin
      m_edge = irq_in & ~m_prev;
      m_elig = m_pend & m_mask;
      m_np   = m_pend | m_edge;
      if (m_mode == 0) begin
        if (m_elig != 0) begin
          m_cur  = $clog2(m_elig & (~m_elig + 8'd1));  // lowest set bit
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (int_ack) begin
          m_np   = (m_pend & ~(8'd1 << m_cur)) | m_edge;
          m_mode = 2;
        end
      end else if (int_eoi) m_mode = 0;
      m_pend = m_np;
      if (mask_we) m_mask = mask_in;
      m_prev = irq_in;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("m_int_req", int_req, m_mode == 1);
      chk("m_in_service", in_service, m_mode == 2);
      chk("m_pending", pending_out, m_pend);
      chk("m_mask", mask_out, m_mask);
      if (m_mode == 1) chk("m_vector", int_vector, (10'h3F0 + m_cur) % 1024);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_mask(input logic [7:0] m);
    mask_in = m; mask_we = 1; tick(); mask_we = 0;
  endtask

  task automatic ack();
    int_ack = 1; tick(); int_ack = 0;
  endtask

  task automatic eoi();
    int_eoi = 1; tick(); int_eoi = 0;
  endtask

  int rises;
  logic prev_req;

  initial begin
    reset = 1; irq_in = 0; mask_in = 0; mask_we = 0; int_ack = 0; int_eoi = 0;
    tick(); tick();
    chk("rst_req", int_req, 0);
    chk("rst_vec", int_vector, 10'h3F0);
    chk("rst_pend", pending_out, 0);
    reset = 0;

    // Single source
    set_mask(8'h01);
    irq_in = 8'h01; tick();
    chk("t2_pend", pending_out, 8'h01);
    chk("t2_req_early", int_req, 0);
    tick();
    chk("t2_req", int_req, 1);
    chk("t2_vec", int_vector, 10'h3F0);
    irq_in = 0;
    ack();
    chk("t2_pend_clr", pending_out, 0);
    chk("t2_insvc", in_service, 1);
    eoi();
    chk("t2_insvc_off", in_service, 0);

    // Priority
    set_mask(8'hFF);
    irq_in = 8'hA0; tick(); irq_in = 0; tick();
    chk("t3_vec5", int_vector, 10'h3F5);
    ack(); eoi(); tick();
    chk("t3_req7", int_req, 1);
    chk("t3_vec7", int_vector, 10'h3F7);
    ack(); eoi();

    // Mask
    set_mask(8'h00);
    irq_in = 8'h04; tick(); irq_in = 0; tick(); tick();
    chk("t4_pend", pending_out, 8'h04);
    chk("t4_req_masked", int_req, 0);
    set_mask(8'h04);
    chk("t4_req_early", int_req, 0);
    tick();
    chk("t4_req", int_req, 1);
    chk("t4_vec", int_vector, 10'h3F2);
    ack(); eoi();

    // Collision: new edge on the line being acknowledged
    set_mask(8'h08);
    irq_in = 8'h08; tick(); irq_in = 0; tick();
    chk("t5_vec", int_vector, 10'h3F3);
    irq_in = 8'h08; int_ack = 1; tick(); int_ack = 0; irq_in = 0;
    chk("t5_pend_kept", pending_out, 8'h08);
    chk("t5_insvc", in_service, 1);
    eoi();
    chk("t5_idle", int_req, 0);
    tick();
    chk("t5_rereq", int_req, 1);
    chk("t5_revec", int_vector, 10'h3F3);
    int_ack = 1; int_eoi = 1; tick(); int_ack = 0; int_eoi = 0;
    chk("t5_ack_only", in_service, 1);
    eoi();

    // Reset in the middle of a request
    set_mask(8'hFF);
    irq_in = 8'h02; tick(); tick();
    chk("t1_pre_req", int_req, 1);
    #2 reset = 1; #1;
    chk("t1_req", int_req, 0);
    chk("t1_pend", pending_out, 0);
    chk("t1_mask", mask_out, 0);
    chk("t1_vec", int_vector, 10'h3F0);
    irq_in = 0; tick(); reset = 0;

    // Timer with period 7 plus misplaced handshake pulses
    set_mask(8'h01);
    rises = 0; prev_req = 0;
    for (int c = 0; c < 70; c++) begin
      irq_in  = (c < 56 && c % 7 == 0) ? 8'h01 : 8'h00;
      int_ack = int_req || (in_service && c % 3 == 0);
      int_eoi = (in_service && c % 3 == 1) || (!int_req && !in_service && c % 2 == 0);
      tick();
      if (int_req && !prev_req) rises++;
      prev_req = int_req;
    end
    irq_in = 0; int_ack = 0; int_eoi = 0;
    chk("t6_rises", rises, 8);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
